// File: rtl/hello_world_core.sv
// Pad-side demo block: 6-bit accumulator of a 3-bit code, delayed code copy,
// per-bit rise pulses and a 1->2->3 sequence detector. All outputs are registered.
module hello_world_core (
    input  logic bertaClock,
    input  logic global_reset,
    input  logic test,
    input  logic x23,
    input  logic x24,
    input  logic x25,
    output logic z0re,
    output logic z1re,
    output logic z2re,
    output logic z3re,
    output logic z4re,
    output logic z5re,
    output logic u34fe,
    output logic u35fe,
    output logic u36fe,
    output logic u37ah,
    output logic u38ah,
    output logic u39ah,
    output logic z50al,
    output logic z51al,
    output logic n44,
    output logic test_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S2   = 2'b10,
        HIT  = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] x;
    logic [2:0] x_d;
    logic [2:0] rise;
    logic [5:0] z;
    logic       test_q;

    assign x = {x25, x24, x23};

    // test only holds the accumulator; delay, rise and echo keep running
    always_ff @(posedge bertaClock or negedge global_reset) begin
        if (!global_reset) begin
            z      <= '0;
            x_d    <= '0;
            rise   <= '0;
            test_q <= 1'b0;
        end else begin
            x_d    <= x;
            rise   <= x & ~x_d;
            test_q <= test;
            if (!test) begin
                z <= z + {3'b000, x};
            end
        end
    end

    always_ff @(posedge bertaClock or negedge global_reset) begin
        if (!global_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: state_nxt = (x == 3'd1) ? S1 : IDLE;
            S1: begin
                if (x == 3'd2)      state_nxt = S2;
                else if (x == 3'd1) state_nxt = S1;
                else                state_nxt = IDLE;
            end
            S2: begin
                if (x == 3'd3)      state_nxt = HIT;
                else if (x == 3'd1) state_nxt = S1;
                else                state_nxt = IDLE;
            end
            HIT:     state_nxt = (x == 3'd1) ? S1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        z0re   = z[0];
        z1re   = z[1];
        z2re   = z[2];
        z3re   = z[3];
        z4re   = z[4];
        z5re   = z[5];
        u34fe  = x_d[0];
        u35fe  = x_d[1];
        u36fe  = x_d[2];
        u37ah  = rise[0];
        u38ah  = rise[1];
        u39ah  = rise[2];
        z50al  = ~state[0];
        z51al  = ~state[1];
        n44    = (state == HIT);
        test_o = test_q;
    end

endmodule

// File: tb/tb_hello_world_core.sv
// Scoreboard bench for hello_world_core: directed vectors push hand-computed
// expectations; a monitor pops one per clock (or per async-reset probe) and compares.
module tb_hello_world_core;

    logic bertaClock = 1'b0;
    logic global_reset = 1'b0;
    logic test = 1'b0;
    logic x23 = 1'b0, x24 = 1'b0, x25 = 1'b0;
    logic z0re, z1re, z2re, z3re, z4re, z5re;
    logic u34fe, u35fe, u36fe, u37ah, u38ah, u39ah;
    logic z50al, z51al, n44, test_o;

    hello_world_core dut (
        .bertaClock  (bertaClock),
        .global_reset(global_reset),
        .test        (test),
        .x23         (x23),
        .x24         (x24),
        .x25         (x25),
        .z0re        (z0re),
        .z1re        (z1re),
        .z2re        (z2re),
        .z3re        (z3re),
        .z4re        (z4re),
        .z5re        (z5re),
        .u34fe       (u34fe),
        .u35fe       (u35fe),
        .u36fe       (u36fe),
        .u37ah       (u37ah),
        .u38ah       (u38ah),
        .u39ah       (u39ah),
        .z50al       (z50al),
        .z51al       (z51al),
        .n44         (n44),
        .test_o      (test_o)
    );

    always #5 bertaClock = ~bertaClock;

    typedef struct packed {
        logic [5:0] z;
        logic [2:0] xd;
        logic [2:0] rise;
        logic [1:0] st;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event async_ev;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor: one expectation per clock edge or async probe
    initial begin
        exp_t e;
        forever begin
            @(posedge bertaClock or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("z",      int'({z5re, z4re, z3re, z2re, z1re, z0re}), int'(e.z));
                chk("x_d",    int'({u36fe, u35fe, u34fe}), int'(e.xd));
                chk("rise",   int'({u39ah, u38ah, u37ah}), int'(e.rise));
                chk("state",  int'({~z51al, ~z50al}), int'(e.st));
                chk("n44",    int'(n44), int'(e.st == 2'd3));
                chk("test_o", int'(test_o), int'(e.to));
            end
        end
    end

    task automatic vec(input logic r, input logic t, input logic [2:0] xv,
                       input logic [5:0] ez, input logic [2:0] exd,
                       input logic [2:0] erise, input logic [1:0] est, input logic eto);
        exp_t e;
        @(negedge bertaClock);
        global_reset = r;
        test = t;
        {x25, x24, x23} = xv;
        e.z = ez; e.xd = exd; e.rise = erise; e.st = est; e.to = eto;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        // reset held low
        vec(0, 0, 3'd0,  0, 0, 0, 0, 0);
        vec(0, 0, 3'd0,  0, 0, 0, 0, 0);
        // x=5 accumulation, rise pulses once
        vec(1, 0, 3'd5,  5, 5, 5, 0, 0);
        vec(1, 0, 3'd5, 10, 5, 0, 0, 0);
        vec(1, 0, 3'd5, 15, 5, 0, 0, 0);
        // climb to 60
        vec(1, 0, 3'd7, 22, 7, 2, 0, 0);
        vec(1, 0, 3'd7, 29, 7, 0, 0, 0);
        vec(1, 0, 3'd7, 36, 7, 0, 0, 0);
        vec(1, 0, 3'd7, 43, 7, 0, 0, 0);
        vec(1, 0, 3'd7, 50, 7, 0, 0, 0);
        vec(1, 0, 3'd7, 57, 7, 0, 0, 0);
        vec(1, 0, 3'd3, 60, 3, 0, 0, 0);
        // wrap 60+7 -> 3
        vec(1, 0, 3'd7,  3, 7, 4, 0, 0);
        // test freezes z
        vec(1, 1, 3'd7,  3, 7, 0, 0, 1);
        vec(1, 1, 3'd7,  3, 7, 0, 0, 1);
        vec(1, 1, 3'd7,  3, 7, 0, 0, 1);
        vec(1, 1, 3'd7,  3, 7, 0, 0, 1);
        // 1,2,3,0 -> S1,S2,HIT,IDLE
        vec(1, 0, 3'd1,  4, 1, 0, 1, 0);
        vec(1, 0, 3'd2,  6, 2, 2, 2, 0);
        vec(1, 0, 3'd3,  9, 3, 1, 3, 0);
        vec(1, 0, 3'd0,  9, 0, 0, 0, 0);
        // 1,2,2 -> S1,S2,IDLE
        vec(1, 0, 3'd1, 10, 1, 1, 1, 0);
        vec(1, 0, 3'd2, 12, 2, 2, 2, 0);
        vec(1, 0, 3'd2, 14, 2, 0, 0, 0);
        // 1,1,2,3 -> HIT
        vec(1, 0, 3'd1, 15, 1, 1, 1, 0);
        vec(1, 0, 3'd1, 16, 1, 0, 1, 0);
        vec(1, 0, 3'd2, 18, 2, 2, 2, 0);
        vec(1, 0, 3'd3, 21, 3, 1, 3, 0);
        // HIT restarted by 1, then to HIT again
        vec(1, 0, 3'd1, 22, 1, 0, 1, 0);
        vec(1, 0, 3'd2, 24, 2, 2, 2, 0);
        vec(1, 0, 3'd3, 27, 3, 1, 3, 0);
        // asynchronous reset between edges while in HIT
        @(negedge bertaClock);
        #2;
        global_reset = 1'b0;
        e = '0;
        exp_q.push_back(e);
        -> async_ev;
        // recovery from reset
        vec(1, 0, 3'd1,  1, 1, 1, 1, 0);
        vec(1, 0, 3'd0,  1, 0, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge bertaClock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
